// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: turns EX-resolved call/branch/ret events and
// ID load-use hazards into fetch stall/flush/redirect controls. A circular
// return-address stack lets Ret redirect immediately. When the stack is
// empty, the controller waits for the return address from data memory.
module fetch_redirect_ctrl #(
  parameter int AW           = 16,
  parameter int RAS_DEPTH    = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_call,
  input  logic          ex_branch,
  input  logic          ex_ret,
  input  logic [AW-1:0] ex_target,
  input  logic [AW-1:0] ex_pc_inc,
  input  logic          id_load_use,
  input  logic          mem_ret_valid,
  input  logic [AW-1:0] mem_ret_addr,
  output logic          stall,
  output logic          flush,
  output logic          Call,
  output logic          Branch,
  output logic          Ret,
  output logic [AW-1:0] PCcall,
  output logic [AW-1:0] PCbranch,
  output logic [AW-1:0] PCret,
  output logic          ras_empty,
  output logic          ras_overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  typedef enum logic [0:0] {ST_IDLE, ST_RET_WAIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [PW-1:0]   ras_ptr_q, ras_ptr_d;   // next free slot; top is ptr-1
  logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
  logic            ras_ovf_q, ras_ovf_d;
  logic [AW-1:0]   ras_mem [RAS_DEPTH];
  logic            call_q, branch_q, ret_q;
  logic [AW-1:0]   pccall_q, pcbranch_q, pcret_q;

  logic            accept;
  logic            do_call, do_branch, do_ret_pop, mem_done, redirect;
  logic            ras_full;
  logic [AW-1:0]   ras_top;

  assign accept   = (state_q == ST_IDLE) && (flush_cnt_q == 3'd0);
  assign ras_full = (ras_cnt_q == CW'(RAS_DEPTH));
  assign ras_top  = ras_mem[ras_ptr_q - PW'(1)];
  assign redirect = do_call | do_branch | do_ret_pop | mem_done;

  // FSM next state and event decode (call > branch > ret)
  always_comb begin
    state_d    = state_q;
    do_call    = 1'b0;
    do_branch  = 1'b0;
    do_ret_pop = 1'b0;
    mem_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ex_call) begin
            do_call = 1'b1;
          end else if (ex_branch) begin
            do_branch = 1'b1;
          end else if (ex_ret) begin
            if (ras_cnt_q != '0) do_ret_pop = 1'b1;
            else                 state_d    = ST_RET_WAIT;
          end
        end
      end
      ST_RET_WAIT: begin
        if (mem_ret_valid) begin
          mem_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAS pointer/count/overflow and flush counter next state
  always_comb begin
    ras_ptr_d   = ras_ptr_q;
    ras_cnt_d   = ras_cnt_q;
    ras_ovf_d   = ras_ovf_q;
    flush_cnt_d = flush_cnt_q;
    if (do_call) begin
      ras_ptr_d = ras_ptr_q + PW'(1);
      if (ras_full) ras_ovf_d = 1'b1;        // oldest entry gets overwritten
      else          ras_cnt_d = ras_cnt_q + CW'(1);
    end else if (do_ret_pop) begin
      ras_ptr_d = ras_ptr_q - PW'(1);
      ras_cnt_d = ras_cnt_q - CW'(1);
    end
    if (redirect)                flush_cnt_d = FLUSH_INIT;
    else if (flush_cnt_q != '0)  flush_cnt_d = flush_cnt_q - 3'd1;
  end

  // State, RAS bookkeeping and flush counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      ras_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      ras_ovf_q   <= ras_ovf_d;
    end
  end

  // RAS storage: contents are meaningless once count is cleared, so no reset
  always_ff @(posedge clk) begin
    if (do_call) ras_mem[ras_ptr_q] <= ex_pc_inc;
  end

  // Registered one-cycle redirect selects with held targets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      call_q     <= 1'b0;
      branch_q   <= 1'b0;
      ret_q      <= 1'b0;
      pccall_q   <= '0;
      pcbranch_q <= '0;
      pcret_q    <= '0;
    end else begin
      call_q   <= do_call;
      branch_q <= do_branch;
      ret_q    <= do_ret_pop | mem_done;
      if (do_call)        pccall_q   <= ex_target;
      if (do_branch)      pcbranch_q <= ex_target;
      if (do_ret_pop)     pcret_q    <= ras_top;
      else if (mem_done)  pcret_q    <= mem_ret_addr;
    end
  end

  assign stall        = id_load_use | (state_q == ST_RET_WAIT);
  assign flush        = (flush_cnt_q != 3'd0);
  assign Call         = call_q;
  assign Branch       = branch_q;
  assign Ret          = ret_q;
  assign PCcall       = pccall_q;
  assign PCbranch     = pcbranch_q;
  assign PCret        = pcret_q;
  assign ras_empty    = (ras_cnt_q == '0);
  assign ras_overflow = ras_ovf_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: a queue-based reference model is
// compared against the DUT every cycle, plus literal spot checks.
module tb_fetch_redirect_ctrl;

  localparam int AW = 16;
  localparam int DEPTH = 8;
  localparam int FLUSH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_call, ex_branch, ex_ret, id_load_use, mem_ret_valid;
  logic [AW-1:0] ex_target, ex_pc_inc, mem_ret_addr;
  logic          stall, flush, Call, Branch, Ret, ras_empty, ras_overflow;
  logic [AW-1:0] PCcall, PCbranch, PCret;

  int checks = 0;
  int failures = 0;

  fetch_redirect_ctrl #(.AW(AW), .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_call(ex_call), .ex_branch(ex_branch), .ex_ret(ex_ret),
    .ex_target(ex_target), .ex_pc_inc(ex_pc_inc),
    .id_load_use(id_load_use), .mem_ret_valid(mem_ret_valid),
    .mem_ret_addr(mem_ret_addr),
    .stall(stall), .flush(flush), .Call(Call), .Branch(Branch), .Ret(Ret),
    .PCcall(PCcall), .PCbranch(PCbranch), .PCret(PCret),
    .ras_empty(ras_empty), .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Reference model: stack as a queue, flush as a count of remaining cycles
  logic [AW-1:0] m_ras[$];
  int            m_flush = 0;
  bit            m_wait = 0, m_ovf = 0, m_call = 0, m_branch = 0, m_ret = 0;
  logic [AW-1:0] m_pccall = '0, m_pcbranch = '0, m_pcret = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ras.delete();
      m_flush = 0; m_wait = 0; m_ovf = 0;
      m_call = 0; m_branch = 0; m_ret = 0;
      m_pccall = '0; m_pcbranch = '0; m_pcret = '0;
    end else begin
      m_call = 0; m_branch = 0; m_ret = 0;
      if (m_flush > 0) m_flush = m_flush - 1;
      if (m_wait) begin
        if (mem_ret_valid) begin
          m_ret = 1; m_pcret = mem_ret_addr; m_wait = 0; m_flush = FLUSH;
        end
      end else if (m_flush == 0 && !(m_call || m_branch)) begin
        if (ex_call) begin
          m_ras.push_back(ex_pc_inc);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
          end
          m_call = 1; m_pccall = ex_target; m_flush = FLUSH;
        end else if (ex_branch) begin
          m_branch = 1; m_pcbranch = ex_target; m_flush = FLUSH;
        end else if (ex_ret) begin
          if (m_ras.size() > 0) begin
            m_pcret = m_ras.pop_back(); m_ret = 1; m_flush = FLUSH;
          end else begin
            m_wait = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check("stall",    32'(stall),        32'(id_load_use | m_wait));
    check("flush",    32'(flush),        32'(m_flush > 0));
    check("Call",     32'(Call),         32'(m_call));
    check("Branch",   32'(Branch),       32'(m_branch));
    check("Ret",      32'(Ret),          32'(m_ret));
    check("PCcall",   32'(PCcall),       32'(m_pccall));
    check("PCbranch", 32'(PCbranch),     32'(m_pcbranch));
    check("PCret",    32'(PCret),        32'(m_pcret));
    check("ras_empty",32'(ras_empty),    32'(m_ras.size() == 0));
    check("ras_ovf",  32'(ras_overflow), 32'(m_ovf));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_call = 0; ex_branch = 0; ex_ret = 0; id_load_use = 0; mem_ret_valid = 0;
  endtask

  initial begin
    rst_n = 0; idle_in();
    ex_target = '0; ex_pc_inc = '0; mem_ret_addr = '0;
    cyc(); cyc();
    check("rst_empty", 32'(ras_empty), 32'd1);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pcret", 32'(PCret), 32'd0);
    rst_n = 1;
    cyc();

    // 1: branch redirect
    $display("txn branch tgt=0040");
    ex_branch = 1; ex_target = 16'h0040; cyc(); idle_in();
    check("t1_branch", 32'(Branch), 32'd1);
    check("t1_pcbranch", 32'(PCbranch), 32'h0040);
    check("t1_flush0", 32'(flush), 32'd1);
    check("t1_call", 32'(Call), 32'd0);
    cyc(); check("t1_flush1", 32'(flush), 32'd1);
    check("t1_pulse_end", 32'(Branch), 32'd0);
    cyc(); check("t1_flush2", 32'(flush), 32'd0);

    // 2: call then ret through RAS
    $display("txn call tgt=0100 ret=0011");
    ex_call = 1; ex_target = 16'h0100; ex_pc_inc = 16'h0011; cyc(); idle_in();
    check("t2_call", 32'(Call), 32'd1);
    check("t2_pccall", 32'(PCcall), 32'h0100);
    cyc(); cyc(); cyc();
    $display("txn ret (ras)");
    ex_ret = 1; cyc(); idle_in();
    check("t2_ret", 32'(Ret), 32'd1);
    check("t2_pcret", 32'(PCret), 32'h0011);
    check("t2_empty", 32'(ras_empty), 32'd1);
    cyc(); cyc();

    // 3: ret with empty RAS waits for memory
    $display("txn ret (empty) mem=0222");
    ex_ret = 1; cyc(); idle_in();
    check("t3_stall", 32'(stall), 32'd1);
    ex_branch = 1; ex_target = 16'h0999; cyc(); cyc(); idle_in();
    check("t3_stall2", 32'(stall), 32'd1);
    check("t3_nobranch", 32'(PCbranch), 32'h0040);
    mem_ret_valid = 1; mem_ret_addr = 16'h0222; cyc(); idle_in();
    check("t3_ret", 32'(Ret), 32'd1);
    check("t3_pcret", 32'(PCret), 32'h0222);
    check("t3_stall_off", 32'(stall), 32'd0);
    cyc(); cyc();
    $display("txn stray mem_ret_valid");
    mem_ret_valid = 1; mem_ret_addr = 16'h0333; cyc(); idle_in();
    check("t3_stray", 32'(PCret), 32'h0222);
    cyc();

    // 4: wrong-path event ignored; call beats branch
    $display("txn branch tgt=0050 then branch tgt=0060 during flush");
    ex_branch = 1; ex_target = 16'h0050; cyc();
    ex_target = 16'h0060; cyc(); idle_in();
    check("t4_ignored", 32'(Branch), 32'd0);
    check("t4_pcbranch", 32'(PCbranch), 32'h0050);
    cyc(); cyc();
    $display("txn call+branch tgt=0070 ret=0071");
    ex_call = 1; ex_branch = 1; ex_target = 16'h0070; ex_pc_inc = 16'h0071; cyc(); idle_in();
    check("t4_call", 32'(Call), 32'd1);
    check("t4_nobranch", 32'(Branch), 32'd0);
    cyc(); cyc();
    ex_ret = 1; ex_branch = 1; cyc(); idle_in();
    check("t4_branch_beats_ret", 32'(Branch), 32'd1);
    cyc(); cyc();
    ex_ret = 1; cyc(); idle_in();
    check("t4_pcret", 32'(PCret), 32'h0071);
    cyc(); cyc();

    // 5: overflow and circular overwrite
    for (int i = 1; i <= 9; i++) begin
      $display("txn call ret=%04h", i);
      ex_call = 1; ex_target = 16'(16'h0200 + i); ex_pc_inc = 16'(i); cyc(); idle_in();
      cyc(); cyc();
    end
    check("t5_ovf", 32'(ras_overflow), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      $display("txn ret #%0d", k);
      ex_ret = 1; cyc(); idle_in();
      check("t5_pcret", 32'(PCret), 32'(10 - k));
      cyc(); cyc();
    end
    $display("txn ret #9 (empty)");
    ex_ret = 1; cyc(); idle_in();
    check("t5_wait", 32'(stall), 32'd1);

    // 6: asynchronous reset during RET_WAIT
    $display("txn async reset in RET_WAIT");
    #2 rst_n = 0;
    #1;
    check("t6_stall", 32'(stall), 32'd0);
    check("t6_empty", 32'(ras_empty), 32'd1);
    check("t6_ovf", 32'(ras_overflow), 32'd0);
    id_load_use = 1; #1;
    check("t6_loaduse", 32'(stall), 32'd1);
    cyc(); idle_in(); rst_n = 1;
    cyc();
    $display("txn load-use");
    id_load_use = 1; cyc(); cyc(); idle_in(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
